// File: rtl/index_to_one_hot_accum.sv
// ---------------------------------------------------------------------------
// index_to_one_hot_accum
//
// Purpose:
//   Turns a stream of binary indices (thread IDs from a fill/wakeup path) into
//   registered multi-hot masks for a scheduler. Indices collect in a pending
//   accumulator (acc). Duplicates coalesce into one bit. The accumulated mask
//   is offered on a valid/ready output. The producer is never stalled: there
//   is no in_ready, and at most one index arrives per cycle.
//
// Handshake:
//   out_mask moves to the consumer on a rising edge where out_valid=1 and
//   out_ready=1. While out_valid=1 and out_ready=0, out_mask and out_valid
//   hold. out_valid only falls after a transfer. out_ready while
//   out_valid=0 is legal and only enables a load. out_valid=1 always comes
//   with a non-zero out_mask.
//
// Ports:
//   clk            clock, rising edge
//   reset_n        asynchronous active-low reset; clears all state at once
//   in_valid       in_index is valid this cycle
//   in_index       binary index to set (values >= NUM_SIGNALS are dropped)
//   out_valid      out_mask holds a non-empty mask
//   out_ready      consumer takes out_mask this cycle when out_valid=1
//   out_mask       registered multi-hot mask
//   pending_count  popcount of acc (bits not yet moved into out_mask)
//   dup_pulse      1-cycle pulse: the accepted index was already set in acc
//   range_error    1-cycle pulse for an out-of-range index (needs the
//                  RANGE_CHECK_EN macro; tied 0 otherwise)
//   o_dbg_state    FSM state (0 = IDLE, 1 = HOLD), for debug and checkers
//
// Build option:
//   RANGE_CHECK_EN  when defined, adds the out-of-range compare and the
//                   registered range_error pulse.
// ---------------------------------------------------------------------------
module index_to_one_hot_accum #(
  parameter int NUM_SIGNALS = 4,
  parameter int INDEX_WIDTH = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [INDEX_WIDTH-1:0] in_index,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_SIGNALS-1:0] out_mask,
  output logic [INDEX_WIDTH:0]   pending_count,
  output logic                   dup_pulse,
  output logic                   range_error,
  output logic [0:0]             o_dbg_state
);

  // Two-state FSM. HOLD means out_mask carries a non-empty mask. It is
  // equivalent to out_valid.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]             r_state;
  logic [NUM_SIGNALS-1:0] r_out_mask;
  logic [NUM_SIGNALS-1:0] r_acc;
  logic [INDEX_WIDTH:0]   r_pending_count;
  logic                   r_dup_pulse;

  logic [NUM_SIGNALS-1:0] w_new_bit;
  logic [NUM_SIGNALS-1:0] w_merged;
  logic [NUM_SIGNALS-1:0] w_acc_next;
  logic                   w_load;
  logic                   w_dup;
  logic [0:0]             w_state_next;

  function automatic logic [INDEX_WIDTH:0] f_popcount(
    input logic [NUM_SIGNALS-1:0] vec
  );
    logic [INDEX_WIDTH:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_SIGNALS; i++) begin
      cnt = cnt + {{INDEX_WIDTH{1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

  // Decode the index by comparing it against each legal position. An index
  // >= NUM_SIGNALS matches no position, so it drops out with no extra logic.
  // This also covers a non-power-of-2 NUM_SIGNALS.
  always_comb begin
    w_new_bit = '0;
    for (int i = 0; i < NUM_SIGNALS; i++) begin
      if (in_valid && (in_index == INDEX_WIDTH'(i))) begin
        w_new_bit[i] = 1'b1;
      end
    end
  end

  // Load when the output register is free or is being taken this cycle.
  // On a load the incoming bit merges with acc straight into out_mask, so a
  // bit arriving in the same cycle as a transfer is neither lost nor
  // duplicated.
  assign w_load     = (r_state == ST_IDLE) || out_ready;
  assign w_merged   = r_acc | w_new_bit;
  assign w_acc_next = w_load ? '0 : w_merged;

  // A duplicate is only a hit against acc. A bit that is sitting in out_mask
  // re-arms in acc instead, because the consumer has not yet seen it again.
  assign w_dup = |(w_new_bit & r_acc);

  always_comb begin
    w_state_next = r_state;
    if (w_load) begin
      w_state_next = (|w_merged) ? ST_HOLD : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_out_mask      <= '0;
      r_acc           <= '0;
      r_pending_count <= '0;
      r_dup_pulse     <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_acc           <= w_acc_next;
      r_pending_count <= f_popcount(w_acc_next);
      r_dup_pulse     <= w_dup;
      if (w_load) begin
        r_out_mask <= w_merged;
      end
    end
  end

`ifdef RANGE_CHECK_EN
  // When NUM_SIGNALS is a power of 2, no index value can reach this limit,
  // so the compare is constant false.
  localparam logic [INDEX_WIDTH:0] LP_NUM_SIGNALS = (INDEX_WIDTH+1)'(NUM_SIGNALS);

  logic r_range_error;
  logic w_out_of_range;

  assign w_out_of_range = in_valid && ({1'b0, in_index} >= LP_NUM_SIGNALS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_range_error <= 1'b0;
    end else begin
      r_range_error <= w_out_of_range;
    end
  end

  assign range_error = r_range_error;
`else
  assign range_error = 1'b0;
`endif

  assign out_valid     = (r_state == ST_HOLD);
  assign out_mask      = r_out_mask;
  assign pending_count = r_pending_count;
  assign dup_pulse     = r_dup_pulse;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_index_to_one_hot_accum.sv
module tb_index_to_one_hot_accum;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int PW = 3;
  localparam int EW = 1 + N + PW + 1 + 1;

`ifdef RANGE_CHECK_EN
  localparam logic EXP_RERR = 1'b1;
`else
  localparam logic EXP_RERR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT, NUM_SIGNALS = 4 ----------------
  logic          in_valid;
  logic [IW-1:0] in_index;
  logic          out_ready;
  logic          out_valid;
  logic [N-1:0]  out_mask;
  logic [PW-1:0] pending_count;
  logic          dup_pulse;
  logic          range_error;
  logic [0:0]    dbg_state;

  index_to_one_hot_accum #(.NUM_SIGNALS(N)) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_index      (in_index),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_mask      (out_mask),
    .pending_count (pending_count),
    .dup_pulse     (dup_pulse),
    .range_error   (range_error),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- DUT, NUM_SIGNALS = 5 (range check) ----------------
  logic       c_valid;
  logic [2:0] c_index;
  logic       c_ready;
  logic       c_out_valid;
  logic [4:0] c_mask;
  logic [3:0] c_pend;
  logic       c_dup;
  logic       c_rerr;
  logic [0:0] c_state;

  index_to_one_hot_accum #(.NUM_SIGNALS(5)) u_dut5 (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (c_valid),
    .in_index      (c_index),
    .out_valid     (c_out_valid),
    .out_ready     (c_ready),
    .out_mask      (c_mask),
    .pending_count (c_pend),
    .dup_pulse     (c_dup),
    .range_error   (c_rerr),
    .o_dbg_state   (c_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  // reference state for random mode
  logic         m_valid;
  logic [N-1:0] m_mask;
  logic [N-1:0] m_acc;

  // invariant tracking for random mode
  logic         prev_valid;
  logic         prev_rdy;
  logic [N-1:0] prev_mask;
  logic [N-1:0] acc_set;
  logic [N-1:0] xfer_set;

  typedef struct {
    logic          v;
    logic [IW-1:0] idx;
    logic          rdy;
    logic          e_valid;
    logic [N-1:0]  e_mask;
    logic [PW-1:0] e_pend;
    logic          e_dup;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out();
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    a = {out_valid, out_mask, pending_count, dup_pulse, range_error};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL out_vec: got valid=%0b mask=%b pend=%0d dup=%0b rerr=%0b expected valid=%0b mask=%b pend=%0d dup=%0b rerr=%0b at %0t",
               a[EW-1], a[EW-2 -: N], a[PW+1 -: PW], a[1], a[0],
               e[EW-1], e[EW-2 -: N], e[PW+1 -: PW], e[1], e[0], $time);
    end
  endtask

  // Reference behaviour: load when output is free or taken, merge new bit
  // with acc, dup is a hit against acc only.
  function automatic logic [EW-1:0] model_step(input logic v, input logic [IW-1:0] idx,
                                               input logic rdy);
    logic [N-1:0] nb;
    logic         dup;
    logic [N-1:0] merged;
    nb     = v ? (N'(1) << idx) : '0;
    dup    = |(nb & m_acc);
    merged = m_acc | nb;
    if (!m_valid || rdy) begin
      m_mask  = merged;
      m_valid = |merged;
      m_acc   = '0;
    end else begin
      m_acc = merged;
    end
    return {m_valid, m_mask, PW'($countones(m_acc)), dup, 1'b0};
  endfunction

  // Drive one cycle. Outputs from the previous edge are compared first.
  task automatic drive(input logic v, input logic [IW-1:0] idx, input logic rdy,
                       input logic use_model, input logic [EW-1:0] e_tbl);
    @(negedge clk);
    check_out();
    if (use_model) begin
      checks++;
      if (out_valid && out_mask == '0) begin
        failures++;
        $display("FAIL valid_zero_mask: got mask=%b expected nonzero", out_mask);
      end
      if (prev_valid && !prev_rdy) begin
        checks++;
        if (!out_valid || out_mask !== prev_mask) begin
          failures++;
          $display("FAIL stable: got valid=%0b mask=%b expected valid=1 mask=%b",
                   out_valid, out_mask, prev_mask);
        end
      end
      if (out_valid && rdy) xfer_set = xfer_set | out_mask;
      if (v) acc_set = acc_set | (N'(1) << idx);
      prev_valid = out_valid;
      prev_mask  = out_mask;
      prev_rdy   = rdy;
    end
    in_valid  = v;
    in_index  = idx;
    out_ready = rdy;
    if (use_model) exp_q.push_back(model_step(v, idx, rdy));
    else           exp_q.push_back(e_tbl);
  endtask

  task automatic drive_vec(input vec_t t);
    drive(t.v, t.idx, t.rdy, 1'b0, {t.e_valid, t.e_mask, t.e_pend, t.e_dup, 1'b0});
  endtask

  task automatic flush();
    @(negedge clk);
    check_out();
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_index  = '0;
    out_ready = 1'b0;
    c_valid   = 1'b0;
    c_index   = '0;
    c_ready   = 1'b0;
    m_valid   = 1'b0;
    m_mask    = '0;
    m_acc     = '0;
    prev_valid = 1'b0;
    prev_rdy   = 1'b0;
    prev_mask  = '0;
    acc_set    = '0;
    xfer_set   = '0;

    // Directed vectors: inputs for one cycle, then the outputs expected
    // after that edge.
    //            v     idx    rdy   valid  mask     pend  dup
    tbl.push_back('{1'b1, 2'd2, 1'b1, 1'b1, 4'b0100, 3'd0, 1'b0}); // first load
    tbl.push_back('{1'b0, 2'd0, 1'b0, 1'b1, 4'b0100, 3'd0, 1'b0}); // hold
    tbl.push_back('{1'b1, 2'd0, 1'b0, 1'b1, 4'b0100, 3'd1, 1'b0}); // into acc
    tbl.push_back('{1'b1, 2'd3, 1'b0, 1'b1, 4'b0100, 3'd2, 1'b0});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 1'b1, 4'b0100, 3'd2, 1'b1}); // dup in acc
    tbl.push_back('{1'b1, 2'd2, 1'b0, 1'b1, 4'b0100, 3'd3, 1'b0}); // in out_mask: re-arm
    tbl.push_back('{1'b0, 2'd0, 1'b1, 1'b1, 4'b1101, 3'd0, 1'b0}); // release stall
    tbl.push_back('{1'b1, 2'd1, 1'b0, 1'b1, 4'b1101, 3'd1, 1'b0});
    tbl.push_back('{1'b1, 2'd1, 1'b1, 1'b1, 4'b0010, 3'd0, 1'b1}); // merge on transfer
    tbl.push_back('{1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0}); // empty load
    tbl.push_back('{1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 2'd3, 1'b0, 1'b1, 4'b1000, 3'd0, 1'b0}); // load from IDLE
    tbl.push_back('{1'b1, 2'd3, 1'b1, 1'b1, 4'b1000, 3'd0, 1'b0}); // back-to-back
    tbl.push_back('{1'b1, 2'd0, 1'b0, 1'b1, 4'b1000, 3'd1, 1'b0}); // fill acc
    tbl.push_back('{1'b1, 2'd1, 1'b0, 1'b1, 4'b1000, 3'd2, 1'b0});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 1'b1, 4'b1000, 3'd3, 1'b0});
    tbl.push_back('{1'b1, 2'd3, 1'b0, 1'b1, 4'b1000, 3'd4, 1'b0});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 1'b1, 4'b1000, 3'd4, 1'b1}); // saturated
    tbl.push_back('{1'b0, 2'd0, 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_mask", 32'(out_mask), 32'd0);
    chk("reset_pend", 32'(pending_count), 32'd0);
    chk("reset_dup", 32'(dup_pulse), 32'd0);
    chk("reset_rerr", 32'(range_error), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) drive_vec(tbl[i]);
    flush();

    // Asynchronous reset in the middle of HOLD, with acc non-zero.
    drive(1'b1, 2'd1, 1'b1, 1'b0, {1'b1, 4'b0010, 3'd0, 1'b0, 1'b0});
    drive(1'b1, 2'd2, 1'b0, 1'b0, {1'b1, 4'b0010, 3'd1, 1'b0, 1'b0});
    flush();
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_mask", 32'(out_mask), 32'd0);
    chk("async_pend", 32'(pending_count), 32'd0);
    chk("async_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 2'd0, 1'b1, 1'b0, {1'b0, 4'b0000, 3'd0, 1'b0, 1'b0});
    drive(1'b0, 2'd0, 1'b0, 1'b0, {1'b0, 4'b0000, 3'd0, 1'b0, 1'b0});
    drive(1'b0, 2'd0, 1'b1, 1'b0, {1'b0, 4'b0000, 3'd0, 1'b0, 1'b0});
    flush();

    // Random traffic against the reference model (DUT is empty and idle).
    m_valid  = 1'b0;
    m_mask   = '0;
    m_acc    = '0;
    prev_valid = out_valid;
    prev_mask  = out_mask;
    prev_rdy   = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom_range(0, 9) < 6), IW'($urandom_range(0, N - 1)),
            ($urandom_range(0, 1) == 1), 1'b1, '0);
    end
    repeat (3) drive(1'b0, 2'd0, 1'b1, 1'b1, '0);
    flush();
    chk("no_loss", 32'(xfer_set), 32'(acc_set));
    chk("drained_valid", 32'(out_valid), 32'd0);

    // NUM_SIGNALS = 5: out-of-range index, then the top legal index.
    @(negedge clk);
    c_valid = 1'b1;
    c_index = 3'd6;
    c_ready = 1'b1;
    @(negedge clk);
    chk("n5_rerr", 32'(c_rerr), 32'(EXP_RERR));
    chk("n5_oor_valid", 32'(c_out_valid), 32'd0);
    chk("n5_oor_mask", 32'(c_mask), 32'd0);
    c_index = 3'd4;
    @(negedge clk);
    chk("n5_rerr_clear", 32'(c_rerr), 32'd0);
    chk("n5_mask4", 32'(c_mask), 32'h10);
    chk("n5_valid4", 32'(c_out_valid), 32'd1);
    c_valid = 1'b0;
    @(negedge clk);
    chk("n5_idle", 32'(c_out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
